mode2_sub_stream: RTL

Consumer end of the softmax max-reduction path: once the running maximum of a row is final, this block latches it and streams 4-lane fp16 vectors through a 2-stage pipeline. Each output lane is `inp_i - max`, which feeds the exponent stage. A valid/ready handshake on both sides and a row counter make it a self-contained per-row sequencer. It sits between the mode1 max reduction and the mode2 exp stage.

---
 rtl/mode2_sub_stream.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mode2_sub_stream.sv
// mode2_sub_stream
//
// Consumer end of the softmax max-reduction path. It latches the final row
// maximum and streams 4-lane fp16 vectors through a two-stage pipeline. Each
// output lane is inp_i - max, which feeds the exponent stage. A row counter
// makes the block a self-contained per-row sequencer.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   max_valid             loads max_in / row_len (honored only while idle)
//   max_in, row_len       final row maximum, number of vectors in the row
//   in_valid / in_ready   input handshake for lanes inp0..inp3
//   out_valid / out_ready output handshake for lanes outp0..outp3
//   busy                  a row is in progress (RUN or DRAIN)
//   done                  one-cycle pulse when the last vector of a row leaves
//
// The subtractor implements IEEE half-precision subtraction with
// round-to-nearest-even. It fully supports subnormals. Every invalid
// operation returns the canonical quiet NaN 0x7E00.
module mode2_sub_stream #(
  parameter int DATAWIDTH = 16,
  parameter int ROWLEN_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 max_valid,
  input  logic [DATAWIDTH-1:0] max_in,
  input  logic [ROWLEN_W-1:0]  row_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] inp0,
  input  logic [DATAWIDTH-1:0] inp1,
  input  logic [DATAWIDTH-1:0] inp2,
  input  logic [DATAWIDTH-1:0] inp3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] outp0,
  output logic [DATAWIDTH-1:0] outp1,
  output logic [DATAWIDTH-1:0] outp2,
  output logic [DATAWIDTH-1:0] outp3,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [DATAWIDTH-1:0]            max_q, max_d;
  logic [ROWLEN_W-1:0]             remaining_q, remaining_d;
  logic                            zero_done_q, zero_done_d;
  logic                            a_valid_q, a_valid_d;
  logic                            b_valid_q, b_valid_d;
  logic [3:0][DATAWIDTH-1:0]       a_data_q, a_data_d;
  logic [3:0][DATAWIDTH-1:0]       b_data_q, b_data_d;
  logic                            stall;
  logic                            in_xfer;
  logic                            drain_done;

  // Half-precision a - b with round-to-nearest-even. The smaller operand is
  // aligned using guard, round and sticky bits. Cancellation is renormalised
  // with left shifts, but the exponent never drops below 1 so that the
  // result can become subnormal.
  function automatic logic [15:0] fp16_sub(input logic [15:0] a, input logic [15:0] b);
    logic        sb, sx, sy, a_nan, b_nan, a_inf, b_inf, rnd_up;
    logic [4:0]  xe, ye, ex, ey, shift;
    logic [9:0]  xf, yf;
    logic [13:0] mx, my;
    logic [43:0] aligned;
    logic [14:0] acc;
    logic [5:0]  er;
    logic [11:0] m_rnd;
    logic [15:0] res;
    sb    = ~b[15];
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
    res   = 16'h0000;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != sb))) begin
      res = 16'h7E00;
    end else if (a_inf) begin
      res = {a[15], 5'h1F, 10'h000};
    end else if (b_inf) begin
      res = {sb, 5'h1F, 10'h000};
    end else begin
      if (a[14:0] >= b[14:0]) begin
        sx = a[15]; xe = a[14:10]; xf = a[9:0];
        sy = sb;    ye = b[14:10]; yf = b[9:0];
      end else begin
        sx = sb;    xe = b[14:10]; xf = b[9:0];
        sy = a[15]; ye = a[14:10]; yf = a[9:0];
      end
      ex      = (xe == 5'd0) ? 5'd1 : xe;
      ey      = (ye == 5'd0) ? 5'd1 : ye;
      shift   = ex - ey;
      mx      = {(xe != 5'd0), xf, 3'b000};
      aligned = {(ye != 5'd0), yf, 3'b000, 30'd0} >> shift;
      my      = {aligned[43:31], aligned[30] | (|aligned[29:0])};
      er      = {1'b0, ex};
      if (sx == sy) begin
        acc = {1'b0, mx} + {1'b0, my};
        if (acc[14]) begin
          acc = {1'b0, acc[14:2], acc[1] | acc[0]};
          er  = er + 6'd1;
        end
      end else begin
        acc = {1'b0, mx} - {1'b0, my};
        for (int i = 0; i < 13; i++) begin
          if (!acc[13] && (er > 6'd1)) begin
            acc = acc << 1;
            er  = er - 6'd1;
          end
        end
      end
      if (acc == 15'd0) begin
        // Exact cancellation gives +0. Only (-0) + (-0) keeps the sign.
        res = (sx == sy) ? {sx, 15'd0} : 16'h0000;
      end else begin
        rnd_up = acc[2] && (acc[1] || acc[0] || acc[3]);
        m_rnd  = {1'b0, acc[13:3]} + {11'd0, rnd_up};
        if (m_rnd[11]) begin
          m_rnd = m_rnd >> 1;
          er    = er + 6'd1;
        end
        if (er >= 6'd31) res = {sx, 5'h1F, 10'h000};
        else             res = {sx, (m_rnd[10] ? er[4:0] : 5'd0), m_rnd[9:0]};
      end
    end
    return res;
  endfunction

  // Row sequencing. done comes from two sources. A zero-length row raises a
  // registered flag. The end of DRAIN raises done combinationally, so that
  // the pulse lines up with the final output transfer.
  always_comb begin
    stall       = b_valid_q && !out_ready;
    in_ready    = (state_q == RUN) && (remaining_q != '0) && !stall;
    in_xfer     = in_valid && in_ready;
    drain_done  = !a_valid_q && (!b_valid_q || out_ready);
    state_d     = state_q;
    max_d       = max_q;
    remaining_d = remaining_q;
    zero_done_d = 1'b0;
    done        = zero_done_q;
    case (state_q)
      IDLE: begin
        if (max_valid) begin
          max_d       = max_in;
          remaining_d = row_len;
          if (row_len != '0) state_d = RUN;
          else               zero_done_d = 1'b1;
        end
      end
      RUN: begin
        if (in_xfer) begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == ROWLEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pipeline next-state. Both stages move together, and a stall freezes
  // both of them. Data registers load only alongside a valid, so idle
  // cycles leave the last result on the outputs.
  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    b_valid_d = b_valid_q;
    b_data_d  = b_data_q;
    if (!stall) begin
      a_valid_d = in_xfer;
      if (in_xfer) a_data_d = {inp3, inp2, inp1, inp0};
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        for (int i = 0; i < 4; i++) b_data_d[i] = fp16_sub(a_data_q[i], max_q);
      end
    end
  end

  // All state registers. Reset clears everything, so a mid-row reset
  // flushes the pipeline without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      max_q       <= '0;
      remaining_q <= '0;
      zero_done_q <= 1'b0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      a_data_q    <= '0;
      b_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      remaining_q <= remaining_d;
      zero_done_q <= zero_done_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      a_data_q    <= a_data_d;
      b_data_q    <= b_data_d;
    end
  end

  assign out_valid = b_valid_q;
  assign outp0     = b_data_q[0];
  assign outp1     = b_data_q[1];
  assign outp2     = b_data_q[2];
  assign outp3     = b_data_q[3];
  assign busy      = (state_q != IDLE);

endmodule
